// File: rtl/mem_access_unit.sv
// ============================================================================
// mem_access_unit
// ----------------------------------------------------------------------------
// Load/store unit between the EX/MEM pipeline register and a data memory with
// a req/ack handshake. A legal access is latched in IDLE. The request is held
// through BUSY until the memory acks it. DONE then presents the result for one
// cycle. Misaligned or unsupported accesses raise MisalignOut and never reach
// the memory. A request that gets no ack within TIMEOUT cycles raises
// BusErrOut and is dropped.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   MemWrtAddressIn     byte address of the access
//   MemWrtDataIn        right-aligned store data
//   funct3In            size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   MemRdEnIn           load request
//   MemWrtEnIn          store request (wins when both enables are set)
//   RegDstIn            load destination register
//   DmemReq/We/Addr/Wdata/Be   memory request, held stable while BUSY
//   DmemAck, DmemRdata  memory completion; rdata valid with ack
//   StallOut            holds the upstream pipeline register
//   ValidOut            one-cycle completion pulse (DONE)
//   LoadDataOut         extended load result (0 for stores)
//   RegDstOut           destination of the completed access
//   MisalignOut         one-cycle pulse for an illegal access
//   BusErrOut           one-cycle pulse when the ack timed out
// Lane logic assumes DATA_W = 32 (four byte lanes).
// ============================================================================
module mem_access_unit #(
    parameter int         DATA_W  = 32,
    parameter logic [3:0] TIMEOUT = 4'd15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] MemWrtAddressIn,
    input  logic [DATA_W-1:0] MemWrtDataIn,
    input  logic [2:0]        funct3In,
    input  logic              MemRdEnIn,
    input  logic              MemWrtEnIn,
    input  logic [4:0]        RegDstIn,
    output logic              DmemReq,
    output logic              DmemWe,
    output logic [DATA_W-1:0] DmemAddr,
    output logic [DATA_W-1:0] DmemWdata,
    output logic [3:0]        DmemBe,
    input  logic              DmemAck,
    input  logic [DATA_W-1:0] DmemRdata,
    output logic              StallOut,
    output logic              ValidOut,
    output logic [DATA_W-1:0] LoadDataOut,
    output logic [4:0]        RegDstOut,
    output logic              MisalignOut,
    output logic              BusErrOut
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic [1:0]  addr_lo_q;   // byte offset, needed only for load extraction
    logic [2:0]  funct3_q;
    logic [4:0]  regdst_q;
    logic        store_q;
    logic [3:0]  wait_cnt;

    logic              access_req;
    logic              is_store;
    logic              legal;
    logic [1:0]        lo;
    logic [3:0]        be_c;
    logic [DATA_W-1:0] wdata_c;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] load_ext;

    assign access_req = MemRdEnIn | MemWrtEnIn;
    assign is_store   = MemWrtEnIn;   // a simultaneous read is dropped
    assign lo         = MemWrtAddressIn[1:0];

    // Legality check and store lane placement for the incoming access.
    always_comb begin
        // NOTE: every combinational output gets a default first so that no
        // branch can leave it unassigned and infer a latch.
        legal   = 1'b0;
        be_c    = 4'b1111;
        wdata_c = MemWrtDataIn;
        case (funct3In)
            3'b000: begin
                legal = 1'b1;
                if (is_store) begin
                    be_c    = 4'b0001 << lo;
                    wdata_c = {4{MemWrtDataIn[7:0]}};
                end
            end
            3'b001: begin
                legal = ~lo[0];
                if (is_store) begin
                    be_c    = lo[1] ? 4'b1100 : 4'b0011;
                    wdata_c = {2{MemWrtDataIn[15:0]}};
                end
            end
            3'b010:  legal = (lo == 2'b00);
            3'b100:  legal = ~is_store;
            3'b101:  legal = ~is_store & ~lo[0];
            default: legal = 1'b0;
        endcase
    end

    // Extract and extend the addressed lane of the returned word.
    always_comb begin
        ld_byte  = DmemRdata[{addr_lo_q, 3'b000} +: 8];
        ld_half  = DmemRdata[{addr_lo_q[1], 4'b0000} +: 16];
        load_ext = DmemRdata;
        case (funct3_q)
            3'b000:  load_ext = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
            3'b100:  load_ext = {{(DATA_W-8){1'b0}}, ld_byte};
            3'b001:  load_ext = {{(DATA_W-16){ld_half[15]}}, ld_half};
            3'b101:  load_ext = {{(DATA_W-16){1'b0}}, ld_half};
            default: load_ext = DmemRdata;
        endcase
    end

    // Stall is combinational so the upstream register holds in the very
    // cycle a legal access is accepted.
    assign StallOut = ~rst & ((state == BUSY) |
                              ((state == IDLE) & access_req & legal));

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state       <= IDLE;
            addr_lo_q   <= '0;
            funct3_q    <= '0;
            regdst_q    <= '0;
            store_q     <= 1'b0;
            wait_cnt    <= '0;
            DmemReq     <= 1'b0;
            DmemWe      <= 1'b0;
            DmemAddr    <= '0;
            DmemWdata   <= '0;
            DmemBe      <= '0;
            ValidOut    <= 1'b0;
            LoadDataOut <= '0;
            RegDstOut   <= '0;
            MisalignOut <= 1'b0;
            BusErrOut   <= 1'b0;
        end else begin
            // Pulses default low; they are raised for exactly one cycle below.
            ValidOut    <= 1'b0;
            MisalignOut <= 1'b0;
            BusErrOut   <= 1'b0;
            case (state)
                IDLE: begin
                    if (access_req) begin
                        if (legal) begin
                            addr_lo_q <= lo;
                            funct3_q  <= funct3In;
                            regdst_q  <= RegDstIn;
                            store_q   <= is_store;
                            wait_cnt  <= '0;
                            DmemReq   <= 1'b1;
                            DmemWe    <= is_store;
                            DmemAddr  <= {MemWrtAddressIn[DATA_W-1:2], 2'b00};
                            DmemWdata <= wdata_c;
                            DmemBe    <= be_c;
                            state     <= BUSY;
                        end else begin
                            MisalignOut <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    // Ack wins over a timeout reached in the same cycle.
                    if (DmemAck) begin
                        DmemReq     <= 1'b0;
                        ValidOut    <= 1'b1;
                        LoadDataOut <= store_q ? '0 : load_ext;
                        RegDstOut   <= regdst_q;
                        state       <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                        if (wait_cnt + 4'd1 == TIMEOUT) begin
                            DmemReq   <= 1'b0;
                            BusErrOut <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
